// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes one column low per scan tick, samples the rows,
// classifies each 4-column frame and debounces the result into a hex key code.
module keypad_scan #(
  parameter int SCAN_DIV = 16000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic [1:0] state_dbg
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    col_idx;
  logic [3:0]    row_m;
  logic [3:0]    row_s;

  logic [1:0]    hit_cnt;
  logic          frame_multi;
  logic [1:0]    hit_r;
  logic [1:0]    hit_c;

  logic [3:0]    row_act;
  logic [1:0]    cur_r;
  logic          cur_one;
  logic          cur_multi;
  logic [1:0]    tot_hits;
  logic          frame_end;
  logic          frame_key_ok;
  logic [1:0]    frame_r;
  logic [1:0]    frame_c;
  logic [3:0]    frame_code;

  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rcnt;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick      = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = tick && (col_idx == 2'd3);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  // COL is kept equal to ~(1 << col_idx) by rotating it together with col_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx <= 2'd0;
      COL     <= 4'b1110;
    end else if (tick) begin
      col_idx <= col_idx + 2'd1;
      COL     <= {COL[2:0], COL[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= ROW;
      row_s <= row_m;
    end
  end

  always_comb begin
    row_act   = ~row_s;
    cur_r     = 2'd0;
    cur_one   = 1'b1;
    case (row_act)
      4'b0001: cur_r = 2'd0;
      4'b0010: cur_r = 2'd1;
      4'b0100: cur_r = 2'd2;
      4'b1000: cur_r = 2'd3;
      default: cur_one = 1'b0;
    endcase
    cur_multi = (row_act != 4'b0000) && !cur_one;
  end

  // The frame-end tick's own sample is folded in before the accumulator clears.
  always_comb begin
    tot_hits = hit_cnt;
    if (cur_one && hit_cnt != 2'd2) tot_hits = hit_cnt + 2'd1;
    frame_key_ok = (tot_hits == 2'd1) && !frame_multi && !cur_multi;
    frame_r      = (hit_cnt != 2'd0) ? hit_r : cur_r;
    frame_c      = (hit_cnt != 2'd0) ? hit_c : col_idx;
    frame_code   = key_map(frame_r, frame_c);
  end

  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      hit_cnt     <= 2'd0;
      frame_multi <= 1'b0;
      hit_r       <= 2'd0;
      hit_c       <= 2'd0;
    end else if (tick) begin
      if (cur_one) begin
        if (hit_cnt == 2'd0) begin
          hit_r <= cur_r;
          hit_c <= col_idx;
        end else begin
          frame_multi <= 1'b1;
        end
        hit_cnt <= tot_hits;
      end
      if (cur_multi) frame_multi <= 1'b1;
    end
  end

  // Debounce FSM; only advances on frame-end ticks. key_valid is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 4'h0;
      cnt       <= '0;
      rcnt      <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (frame_key_ok) begin
              cand <= frame_code;
              cnt  <= CW'(1);
              if (DEBOUNCE == 1) begin
                key_code  <= frame_code;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                rcnt      <= '0;
                state     <= HELD;
              end else begin
                state <= DEB;
              end
            end
          end
          DEB: begin
            if (frame_key_ok && frame_code == cand) begin
              if (int'(cnt) + 1 >= DEBOUNCE) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                rcnt      <= '0;
                state     <= HELD;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (frame_key_ok) begin
              cand <= frame_code;
              cnt  <= CW'(1);
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (frame_key_ok && frame_code == cand) begin
              rcnt <= '0;
            end else if (int'(rcnt) + 1 >= DEBOUNCE) begin
              rcnt     <= '0;
              key_down <= 1'b0;
              state    <= IDLE;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
